// File: rtl/wm8731_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wm8731_pkg
// Description : Shared types and constants for the WM8731 I2C write responder:
//               protocol state encoding, register indices, reset defaults.
// Revision    : 1.0  initial release
// ============================================================================
package wm8731_pkg;

    // Protocol states of the responder
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR   = 4'd1,
        S_ACK_A  = 4'd2,
        S_BYTE1  = 4'd3,
        S_ACK_1  = 4'd4,
        S_BYTE2  = 4'd5,
        S_ACK_2  = 4'd6,
        S_IGNORE = 4'd7
    } state_t;

    localparam logic [6:0] C_DEV_ADDR_DEFAULT = 7'h1A;

    // Register indices
    localparam logic [3:0] C_R0      = 4'd0;
    localparam logic [3:0] C_R1      = 4'd1;
    localparam logic [3:0] C_R2      = 4'd2;
    localparam logic [3:0] C_R3      = 4'd3;
    localparam logic [3:0] C_R4      = 4'd4;
    localparam logic [3:0] C_R5      = 4'd5;
    localparam logic [3:0] C_R6      = 4'd6;
    localparam logic [3:0] C_R7      = 4'd7;
    localparam logic [3:0] C_R8      = 4'd8;
    localparam logic [3:0] C_R9      = 4'd9;
    localparam logic [3:0] C_R_RESET = 4'd15;
    localparam int         C_NUM_REGS = 10;

    // Power-on values, element [i] belongs to register Ri
    localparam logic [C_NUM_REGS-1:0][8:0] C_REG_DEFAULTS = {
        9'h000,  // R9
        9'h000,  // R8
        9'h00A,  // R7
        9'h09F,  // R6
        9'h008,  // R5
        9'h00A,  // R4
        9'h079,  // R3
        9'h079,  // R2
        9'h097,  // R1
        9'h097   // R0
    };

endpackage
`default_nettype wire

// File: rtl/wm8731_i2c_responder_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_filter
// Description : Two-flop synchronizer followed by a stability filter for one
//               open-drain I2C line; emits the accepted level and one-cycle
//               rise/fall pulses aligned with the level change.
// Revision    : 1.0  initial release
// ============================================================================
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // A new level is accepted on its FILTER_LEN-th consecutive sample
    localparam logic [2:0] C_LAST = 3'(FILTER_LEN - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic [2:0] r_cnt;
    logic       r_rise;
    logic       r_fall;

    // Synchronize, then count consecutive samples that disagree with the accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= 3'd0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == C_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= 3'd0;
                    r_rise  <= r_sync2;
                    r_fall  <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end else begin
                r_cnt <= 3'd0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/wm8731_i2c_responder.sv
`default_nettype none
// ============================================================================
// Module      : wm8731_i2c_responder
// Description : WM8731 control-port model. Decodes 3-byte I2C writes from
//               oversampled SCL/SDA, ACKs valid bytes and maintains the
//               codec's 9-bit register file (R0..R9, R15 = register reset).
// Revision    : 1.0  initial release
// ============================================================================
module wm8731_i2c_responder
    import wm8731_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = C_DEV_ADDR_DEFAULT,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy
);

    logic w_scl_f, w_scl_rise, w_scl_fall;
    logic w_sda_f, w_sda_rise, w_sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk     (clk),
        .rst     (reset),
        .i_line  (scl_i),
        .o_level (w_scl_f),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk     (clk),
        .rst     (reset),
        .i_line  (sda_i),
        .o_level (w_sda_f),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte1;
    logic       r_sda_oe;
    logic       r_wr_valid;
    logic [6:0] r_wr_addr;
    logic [8:0] r_wr_data;
    logic       r_busy;
    logic [8:0] r_regs [C_NUM_REGS];

    // SDA edges while SCL is steadily high are bus conditions, never data
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_next_byte;
    logic [6:0] w_commit_addr;
    logic [8:0] w_commit_data;

    assign w_start       = w_sda_fall & w_scl_f;
    assign w_stop        = w_sda_rise & w_scl_f;
    assign w_next_byte   = {r_shift[6:0], w_sda_f};
    assign w_commit_addr = r_byte1[7:1];
    assign w_commit_data = {r_byte1[0], w_next_byte};

    // Protocol FSM, ACK driver, write commit and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_byte1    <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 9'd0;
            r_busy     <= 1'b0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= C_REG_DEFAULTS[i];
            end
        end else begin
            r_wr_valid <= 1'b0;
            if (w_stop) begin
                // STOP ends everything; a half-received write is dropped
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 3'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    S_ADDR, S_BYTE1, S_BYTE2: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_next_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_state == S_ADDR) begin
                                    // Write-only device: R/W=1 is refused like a foreign address
                                    r_state <= (w_next_byte == {DEV_ADDR, 1'b0}) ? S_ACK_A : S_IGNORE;
                                end else if (r_state == S_BYTE1) begin
                                    r_byte1 <= w_next_byte;
                                    r_state <= S_ACK_1;
                                end else begin
                                    r_wr_valid <= 1'b1;
                                    r_wr_addr  <= w_commit_addr;
                                    r_wr_data  <= w_commit_data;
                                    if (w_commit_addr < 7'(C_NUM_REGS)) begin
                                        r_regs[w_commit_addr[3:0]] <= w_commit_data;
                                    end else if (w_commit_addr == {3'b000, C_R_RESET} &&
                                                 w_commit_data == 9'd0) begin
                                        for (int i = 0; i < C_NUM_REGS; i++) begin
                                            r_regs[i] <= C_REG_DEFAULTS[i];
                                        end
                                    end
                                    r_state <= S_ACK_2;
                                end
                            end
                        end
                    end
                    S_ACK_A, S_ACK_1, S_ACK_2: begin
                        // First SCL fall starts the ACK slot, second one ends it
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                case (r_state)
                                    S_ACK_A: r_state <= S_BYTE1;
                                    S_ACK_1: r_state <= S_BYTE2;
                                    default: r_state <= S_IGNORE;
                                endcase
                            end
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register read port; unmapped indices read as zero
    always_comb begin
        rd_data = 9'd0;
        if (rd_addr < 4'(C_NUM_REGS)) begin
            rd_data = r_regs[rd_addr];
        end
    end

    assign sda_oe   = r_sda_oe;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;

endmodule
`default_nettype wire
